// File: rtl/regfile_pkg.sv
// Shared types and helpers for the parametrised register file with a busy scoreboard.
package regfile_pkg;

  function automatic int rf_aw(input int nreg);
    return (nreg <= 2) ? 1 : $clog2(nreg);
  endfunction

  localparam int RF_NREG_DEFAULT = 32;
  localparam int RF_AW_DEFAULT   = rf_aw(RF_NREG_DEFAULT);
  localparam int RF_ZERO_REG     = 0;

  typedef logic [RF_AW_DEFAULT-1:0] rf_addr_t;

endpackage

// File: rtl/regfile_scoreboard_sb.sv
// Per-register busy bits for pending writes, with WAW issue stall and flush.
module rf_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREG = 32,
  parameter int NWR  = 2,
  localparam int AW  = rf_aw(NREG)
) (
  input  logic                    clock,
  input  logic                    nReset,
  input  logic                    issueValid,
  input  logic [AW-1:0]           issueRd,
  input  logic [NWR-1:0]          wbValid,
  input  logic [NWR-1:0][AW-1:0]  wbAddr,
  input  logic                    flush,
  output logic                    issueReady,
  output logic [NREG-1:0]         busyVec
);

  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_next;
  logic            wb_hits_rd;

  always_comb begin
    wb_hits_rd = 1'b0;
    for (int j = 0; j < NWR; j++) begin
      if (wbValid[j] && (wbAddr[j] == issueRd)) wb_hits_rd = 1'b1;
    end
    issueReady = !flush &&
                 ((issueRd == AW'(RF_ZERO_REG)) || !busy[issueRd] || wb_hits_rd);
  end

  // Set beats clear so a newly issued write stays pending over an older write-back.
  always_comb begin
    busy_next = busy;
    for (int j = 0; j < NWR; j++) begin
      if (wbValid[j]) busy_next[wbAddr[j]] = 1'b0;
    end
    if (flush) busy_next = '0;
    if (issueValid && issueReady) busy_next[issueRd] = 1'b1;
    busy_next[RF_ZERO_REG] = 1'b0;
  end

  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) busy <= '0;
    else         busy <= busy_next;
  end

  assign busyVec = busy;

endmodule

// File: rtl/regfile_scoreboard.sv
// NREG x XLEN register file with multi-port write-back, optional write-to-read
// bypass and a busy scoreboard for pending writes.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter int NRD    = 2,
  parameter int NWR    = 2,
  parameter int BYPASS = 1,
  localparam int AW    = rf_aw(NREG)
) (
  input  logic                     clock,
  input  logic                     nReset,
  input  logic [NRD-1:0][AW-1:0]   rdAddr,
  output logic [NRD-1:0][XLEN-1:0] rdData,
  output logic [NRD-1:0]           rdBusy,
  input  logic                     issueValid,
  input  logic [AW-1:0]            issueRd,
  output logic                     issueReady,
  input  logic [NWR-1:0]           wbValid,
  input  logic [NWR-1:0][AW-1:0]   wbAddr,
  input  logic [NWR-1:0][XLEN-1:0] wbData,
  input  logic                     flush,
  output logic [NREG-1:0]          busyVec
);

  logic [XLEN-1:0] regs [NREG];
  logic [NRD-1:0]  byp_hit;

  // Entry 0 is never written, so it reads back as zero without a special case.
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      for (int r = 0; r < NREG; r++) regs[r] <= '0;
    end else begin
      for (int j = 0; j < NWR; j++) begin
        if (wbValid[j] && (wbAddr[j] != AW'(RF_ZERO_REG))) regs[wbAddr[j]] <= wbData[j];
      end
    end
  end

  always_comb begin
    rdData  = '0;
    rdBusy  = '0;
    byp_hit = '0;
    for (int i = 0; i < NRD; i++) begin
      rdData[i] = regs[rdAddr[i]];
      for (int j = 0; j < NWR; j++) begin
        if ((BYPASS != 0) && wbValid[j] && (wbAddr[j] == rdAddr[i]) &&
            (rdAddr[i] != AW'(RF_ZERO_REG))) begin
          rdData[i]  = wbData[j];
          byp_hit[i] = 1'b1;
        end
      end
      rdBusy[i] = busyVec[rdAddr[i]] && !byp_hit[i];
    end
    // Forwarded write-back data must not leak out while held in reset.
    if (!nReset) rdData = '0;
  end

  rf_scoreboard #(
    .NREG (NREG),
    .NWR  (NWR)
  ) u_sb (
    .clock      (clock),
    .nReset     (nReset),
    .issueValid (issueValid),
    .issueRd    (issueRd),
    .wbValid    (wbValid),
    .wbAddr     (wbAddr),
    .flush      (flush),
    .issueReady (issueReady),
    .busyVec    (busyVec)
  );

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench: one bypassing and one non-bypassing instance share stimulus
// and are compared against a behavioural register/pending-write model.
module tb_regfile_scoreboard;

  logic             clock = 1'b0;
  logic             nReset;
  logic [1:0][4:0]  rdAddr;
  logic [1:0][31:0] rdData_b, rdData_n;
  logic [1:0]       rdBusy_b, rdBusy_n;
  logic             issueValid;
  logic [4:0]       issueRd;
  logic             issueReady_b, issueReady_n;
  logic [1:0]       wbValid;
  logic [1:0][4:0]  wbAddr;
  logic [1:0][31:0] wbData;
  logic             flush;
  logic [31:0]      busyVec_b, busyVec_n;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] m_regs [32];
  logic [31:0] m_busy;

  always #5 clock = ~clock;

  regfile_scoreboard #(.BYPASS(1)) dut_b (
    .clock(clock), .nReset(nReset), .rdAddr(rdAddr), .rdData(rdData_b), .rdBusy(rdBusy_b),
    .issueValid(issueValid), .issueRd(issueRd), .issueReady(issueReady_b),
    .wbValid(wbValid), .wbAddr(wbAddr), .wbData(wbData), .flush(flush), .busyVec(busyVec_b)
  );

  regfile_scoreboard #(.BYPASS(0)) dut_n (
    .clock(clock), .nReset(nReset), .rdAddr(rdAddr), .rdData(rdData_n), .rdBusy(rdBusy_n),
    .issueValid(issueValid), .issueRd(issueRd), .issueReady(issueReady_n),
    .wbValid(wbValid), .wbAddr(wbAddr), .wbData(wbData), .flush(flush), .busyVec(busyVec_n)
  );

  function automatic bit wb_hits(input int a);
    for (int j = 0; j < 2; j++) if (wbValid[j] && int'(wbAddr[j]) == a) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] exp_rd(input int i, input bit byp);
    logic [31:0] d;
    int a;
    a = int'(rdAddr[i]);
    if (!nReset || a == 0) return 32'h0;
    d = m_regs[a];
    if (byp) for (int j = 0; j < 2; j++) if (wbValid[j] && int'(wbAddr[j]) == a) d = wbData[j];
    return d;
  endfunction

  function automatic bit exp_rdbusy(input int i, input bit byp);
    int a;
    a = int'(rdAddr[i]);
    return m_busy[a] && !(byp && a != 0 && wb_hits(a));
  endfunction

  function automatic bit exp_ready();
    return !flush && (issueRd == 0 || !m_busy[issueRd] || wb_hits(int'(issueRd)));
  endfunction

  task automatic model_clear();
    for (int r = 0; r < 32; r++) m_regs[r] = 32'h0;
    m_busy = 32'h0;
  endtask

  task automatic idle();
    rdAddr = '0; issueValid = 0; issueRd = 0; wbValid = 0; wbAddr = '0; wbData = '0; flush = 0;
  endtask

  // Advance one clock, updating the model from inputs held stable across the edge.
  task automatic tick();
    bit acc;
    acc = issueValid && exp_ready() && issueRd != 0;
    @(posedge clock);
    if (!nReset) model_clear();
    else begin
      for (int j = 0; j < 2; j++) begin
        if (wbValid[j] && wbAddr[j] != 0) begin
          m_regs[wbAddr[j]] = wbData[j];
          m_busy[wbAddr[j]] = 1'b0;
        end
      end
      if (flush) m_busy = 32'h0;
      if (acc) m_busy[issueRd] = 1'b1;
    end
  endtask

  task automatic test_reset();
    nReset = 0; idle();
    wbValid = 2'b11; wbAddr[0] = 5; wbAddr[1] = 6; wbData[0] = 32'hCAFE0001; wbData[1] = 32'hCAFE0002;
    rdAddr[0] = 5; rdAddr[1] = 6;
    model_clear();
    #1;
    n_cmp++; if (rdData_b !== '0) begin n_err++; $display("FAIL reset_rdData got %h exp 0", rdData_b); end
    n_cmp++; if (busyVec_b !== 32'h0 || busyVec_n !== 32'h0) begin n_err++; $display("FAIL reset_busyVec got %h/%h exp 0", busyVec_b, busyVec_n); end
    n_cmp++; if (issueReady_b !== 1'b1) begin n_err++; $display("FAIL reset_issueReady got %b exp 1", issueReady_b); end
    @(negedge clock); idle(); nReset = 1;
  endtask

  task automatic test_bypass();
    @(negedge clock); idle();
    wbValid = 2'b01; wbAddr[0] = 5; wbData[0] = 32'hAAAA0000;
    tick();
    @(negedge clock); idle();
    wbValid = 2'b01; wbAddr[0] = 5; wbData[0] = 32'h12345678; rdAddr[0] = 5;
    #1;
    n_cmp++; if (rdData_b[0] !== 32'h12345678) begin n_err++; $display("FAIL bypass_same_cycle got %h exp 12345678", rdData_b[0]); end
    n_cmp++; if (rdData_n[0] !== 32'hAAAA0000) begin n_err++; $display("FAIL nobypass_old got %h exp aaaa0000", rdData_n[0]); end
    tick();
    @(negedge clock); idle(); rdAddr[0] = 5;
    #1;
    n_cmp++; if (rdData_n[0] !== 32'h12345678 || rdData_b[0] !== 32'h12345678) begin n_err++; $display("FAIL write_next_cycle got %h/%h exp 12345678", rdData_b[0], rdData_n[0]); end
  endtask

  task automatic test_conflict();
    @(negedge clock); idle();
    wbValid = 2'b11; wbAddr[0] = 7; wbAddr[1] = 7; wbData[0] = 32'h1; wbData[1] = 32'h2; rdAddr[1] = 7;
    #1;
    n_cmp++; if (rdData_b[1] !== 32'h2) begin n_err++; $display("FAIL conflict_bypass got %h exp 2", rdData_b[1]); end
    tick();
    @(negedge clock); idle(); rdAddr[1] = 7;
    #1;
    n_cmp++; if (rdData_b[1] !== 32'h2 || rdData_n[1] !== 32'h2) begin n_err++; $display("FAIL conflict_store got %h/%h exp 2", rdData_b[1], rdData_n[1]); end
  endtask

  task automatic test_waw();
    @(negedge clock); idle(); issueValid = 1; issueRd = 3;
    #1;
    n_cmp++; if (issueReady_b !== 1'b1) begin n_err++; $display("FAIL waw_first_ready got %b exp 1", issueReady_b); end
    tick();
    @(negedge clock); idle(); issueValid = 1; issueRd = 3;
    #1;
    n_cmp++; if (busyVec_b[3] !== 1'b1) begin n_err++; $display("FAIL waw_busy_set got %b exp 1", busyVec_b[3]); end
    n_cmp++; if (issueReady_b !== 1'b0 || issueReady_n !== 1'b0) begin n_err++; $display("FAIL waw_stall got %b/%b exp 0", issueReady_b, issueReady_n); end
    tick();
    @(negedge clock); idle(); issueValid = 1; issueRd = 3; wbValid = 2'b10; wbAddr[1] = 3; wbData[1] = 32'h33;
    #1;
    n_cmp++; if (issueReady_b !== 1'b1) begin n_err++; $display("FAIL waw_wb_ready got %b exp 1", issueReady_b); end
    tick();
    @(negedge clock); idle(); wbValid = 2'b01; wbAddr[0] = 3; wbData[0] = 32'h34;
    #1;
    n_cmp++; if (busyVec_b[3] !== 1'b1) begin n_err++; $display("FAIL waw_set_over_clear got %b exp 1", busyVec_b[3]); end
    tick();
    @(negedge clock); idle();
    #1;
    n_cmp++; if (busyVec_b[3] !== 1'b0) begin n_err++; $display("FAIL waw_cleared got %b exp 0", busyVec_b[3]); end
  endtask

  task automatic test_rdbusy();
    @(negedge clock); idle(); issueValid = 1; issueRd = 9;
    tick();
    @(negedge clock); idle(); rdAddr[1] = 9;
    #1;
    n_cmp++; if (rdBusy_b[1] !== 1'b1 || rdBusy_n[1] !== 1'b1) begin n_err++; $display("FAIL rdbusy_pending got %b/%b exp 1", rdBusy_b[1], rdBusy_n[1]); end
    wbValid = 2'b01; wbAddr[0] = 9; wbData[0] = 32'h99;
    #1;
    n_cmp++; if (rdBusy_b[1] !== 1'b0) begin n_err++; $display("FAIL rdbusy_forwarded got %b exp 0", rdBusy_b[1]); end
    n_cmp++; if (rdBusy_n[1] !== 1'b1) begin n_err++; $display("FAIL rdbusy_nobypass got %b exp 1", rdBusy_n[1]); end
    tick();
    @(negedge clock); idle();
    #1;
    n_cmp++; if (busyVec_b[9] !== 1'b0 || busyVec_n[9] !== 1'b0) begin n_err++; $display("FAIL rdbusy_clear got %b/%b exp 0", busyVec_b[9], busyVec_n[9]); end
  endtask

  task automatic test_flush();
    logic [4:0] rds [3];
    rds[0] = 2; rds[1] = 4; rds[2] = 31;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock); idle(); issueValid = 1; issueRd = rds[k];
      tick();
    end
    @(negedge clock); idle();
    flush = 1; issueValid = 1; issueRd = 6; wbValid = 2'b01; wbAddr[0] = 10; wbData[0] = 32'hF1F1F1F1;
    #1;
    n_cmp++; if (busyVec_b !== 32'h8000_0014) begin n_err++; $display("FAIL flush_pre_busy got %h exp 80000014", busyVec_b); end
    n_cmp++; if (issueReady_b !== 1'b0 || issueReady_n !== 1'b0) begin n_err++; $display("FAIL flush_ready got %b/%b exp 0", issueReady_b, issueReady_n); end
    tick();
    @(negedge clock); idle(); rdAddr[0] = 10;
    #1;
    n_cmp++; if (busyVec_b !== 32'h0 || busyVec_n !== 32'h0) begin n_err++; $display("FAIL flush_busyVec got %h/%h exp 0", busyVec_b, busyVec_n); end
    n_cmp++; if (rdData_n[0] !== 32'hF1F1F1F1) begin n_err++; $display("FAIL flush_wb_data got %h exp f1f1f1f1", rdData_n[0]); end
  endtask

  task automatic rand_inputs();
    for (int i = 0; i < 2; i++) rdAddr[i] = 5'($urandom_range(0, 3) == 0 ? $urandom_range(0, 31) : $urandom_range(0, 7));
    for (int j = 0; j < 2; j++) begin
      wbAddr[j] = 5'($urandom_range(0, 7));
      wbData[j] = $urandom;
    end
    wbValid    = 2'($urandom_range(0, 3));
    issueValid = 1'($urandom_range(0, 1));
    issueRd    = 5'($urandom_range(0, 3) == 0 ? $urandom_range(0, 31) : $urandom_range(0, 7));
    flush      = ($urandom_range(0, 15) == 0);
  endtask

  task automatic test_random(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      @(negedge clock);
      rand_inputs();
      #1;
      for (int i = 0; i < 2; i++) begin
        n_cmp++; if (rdData_b[i] !== exp_rd(i, 1)) begin n_err++; $display("FAIL rnd_rdData_b[%0d] cyc %0d got %h exp %h", i, c, rdData_b[i], exp_rd(i, 1)); end
        n_cmp++; if (rdData_n[i] !== exp_rd(i, 0)) begin n_err++; $display("FAIL rnd_rdData_n[%0d] cyc %0d got %h exp %h", i, c, rdData_n[i], exp_rd(i, 0)); end
        n_cmp++; if (rdBusy_b[i] !== exp_rdbusy(i, 1)) begin n_err++; $display("FAIL rnd_rdBusy_b[%0d] cyc %0d got %b exp %b", i, c, rdBusy_b[i], exp_rdbusy(i, 1)); end
        n_cmp++; if (rdBusy_n[i] !== exp_rdbusy(i, 0)) begin n_err++; $display("FAIL rnd_rdBusy_n[%0d] cyc %0d got %b exp %b", i, c, rdBusy_n[i], exp_rdbusy(i, 0)); end
      end
      n_cmp++; if (issueReady_b !== exp_ready() || issueReady_n !== exp_ready()) begin n_err++; $display("FAIL rnd_issueReady cyc %0d got %b/%b exp %b", c, issueReady_b, issueReady_n, exp_ready()); end
      n_cmp++; if (busyVec_b !== m_busy || busyVec_n !== m_busy) begin n_err++; $display("FAIL rnd_busyVec cyc %0d got %h/%h exp %h", c, busyVec_b, busyVec_n, m_busy); end
      tick();
    end
  endtask

  task automatic test_reset_midrun();
    @(negedge clock); idle(); issueValid = 1; issueRd = 5;
    wbValid = 2'b01; wbAddr[0] = 6; wbData[0] = 32'h5A5A5A5A;
    tick();
    @(negedge clock); idle(); nReset = 0;
    #1;
    n_cmp++; if (busyVec_b !== 32'h0 || busyVec_n !== 32'h0) begin n_err++; $display("FAIL midreset_busyVec got %h/%h exp 0", busyVec_b, busyVec_n); end
    tick();
    @(negedge clock); nReset = 1;
    for (int k = 0; k < 16; k++) begin
      rdAddr[0] = 5'(2 * k); rdAddr[1] = 5'(2 * k + 1);
      #1;
      n_cmp++; if (rdData_b !== '0 || rdData_n !== '0) begin n_err++; $display("FAIL midreset_read x%0d got %h/%h exp 0", 2 * k, rdData_b, rdData_n); end
      tick();
      @(negedge clock);
    end
    idle(); issueValid = 1; issueRd = 0;
    wbValid = 2'b11; wbData[0] = 32'hDEADBEEF; wbData[1] = 32'hDEADBEEF;
    #1;
    n_cmp++; if (rdData_b[0] !== 32'h0) begin n_err++; $display("FAIL x0_bypass got %h exp 0", rdData_b[0]); end
    tick();
    @(negedge clock); idle();
    #1;
    n_cmp++; if (rdData_b[0] !== 32'h0 || rdData_n[0] !== 32'h0) begin n_err++; $display("FAIL x0_read got %h/%h exp 0", rdData_b[0], rdData_n[0]); end
    n_cmp++; if (busyVec_b !== 32'h0) begin n_err++; $display("FAIL x0_busy got %h exp 0", busyVec_b); end
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_conflict();
    test_waw();
    test_rdbusy();
    test_flush();
    test_random(400);
    test_reset_midrun();
    test_random(200);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
Parametrised successor to the RV32I general register file. Provides NREG x XLEN storage with NRD combinational read ports and NWR write-back ports. Adds optional write-to-read bypass and a per-register busy scoreboard for pending writes, with issue stall and flush. Sits between decode/issue (read, issue) and the execute/memory write-back stages.

Parameters:
XLEN, 32, data width in bits
NREG, 32, register count; must be a power of 2 and at least 2; index 0 is hardwired zero
NRD, 2, number of read ports
NWR, 2, number of write-back ports
BYPASS, 1, 1 = same-cycle write-back data forwarded to reads; 0 = reads see the register array only
AW, $clog2(NREG), derived address width; not overridable

Ports:
clock  in  1  rising-edge clock
nReset  in  1  asynchronous, active-low reset
rdAddr  in  NRD x AW  read indices
rdData  out  NRD x XLEN  read data
rdBusy  out  NRD  read register has a pending, unforwarded write
issueValid  in  1  instruction with a destination register wants to issue
issueRd  in  AW  destination register of the issuing instruction
issueReady  out  1  issue accepted this cycle when high together with issueValid
wbValid  in  NWR  write-back strobe per port
wbAddr  in  NWR x AW  write-back index per port
wbData  in  NWR x XLEN  write-back data per port
flush  in  1  pipeline flush; drops all pending-write tracking
busyVec  out  NREG  scoreboard state, for debug; bit 0 is always 0

Behaviour:
- Reset (nReset low, asynchronous): all registers = 0; all busy bits = 0. Outputs during reset: rdData = 0, rdBusy = 0, busyVec = 0. issueReady follows its normal equation with busy = 0, so it is 1 unless flush is high.
- Register x0: reads return 0 and are never busy. Writes and issues to x0 are accepted and discarded, with no state change.
- Reads are combinational, with no added latency. A write lands at the clock edge and is visible in the array on the next cycle.
- Bypass (BYPASS=1): if a port has wbValid[j] high and wbAddr[j] == rdAddr[i] != 0, then rdData[i] = wbData[j] in the same cycle. If several ports match, the highest j wins.
- Write conflict: if several ports write the same nonzero address in one cycle, the highest-index port's data is stored.
- rdBusy[i] = busy[rdAddr[i]] and not (BYPASS and a bypass hit on port i).
- Issue readiness: issueReady = !flush and (issueRd == 0, or busy[issueRd] == 0, or any wbValid[j] with wbAddr[j] == issueRd). This is a WAW stall only.
- Issue acceptance (issueValid and issueReady, issueRd != 0): busy[issueRd] = 1 at the next edge. This takes priority over a same-cycle write-back clear to that register, so the newer write stays pending.
- Write-back to a register with busy = 1 clears busy at the next edge unless the issue rule applies. Write-back to a non-busy register still writes data and leaves busy at 0; this is legal.
- Flush: all busy bits = 0 at the next edge. Any write-backs in the flush cycle still update data. issueReady is 0 during the flush cycle, so no issue is accepted.
- busyVec is the registered scoreboard, so it changes only at clock edges or on reset.
- Reset asserted mid-operation: state clears immediately. The first cycle after release behaves as post-reset.

Decomposition:
- Package regfile_pkg:
  - function rf_aw(nreg) returning the address width
  - typedef rf_addr_t as logic [AW-1:0] for the default configuration
  - constant RF_ZERO_REG = 0
- Sub-module rf_scoreboard: the NREG busy bits, the issueReady logic and the set/clear/flush priority.
- The data array and bypass muxing stay in the top module.

Test Plan:
- Reset and x0: pulse nReset low mid-run, then read all indices -> all 0, busyVec = 0. Then write 0xDEADBEEF to x0 and read x0 -> 0.
- Write/read and bypass: wbValid[0]=1, wbAddr=5, wbData=0x12345678, rdAddr[0]=5 in the same cycle -> rdData = 0x12345678 with BYPASS=1. With BYPASS=0 the old value is read, and the new value appears the next cycle.
- Write conflict: ports 0 and 1 both write x7 (0x1, then 0x2) in one cycle -> next-cycle read of x7 = 0x2. A same-cycle bypass read also returns 0x2.
- Scoreboard WAW: issue rd=3 -> busyVec[3]=1 next cycle. Issue rd=3 again -> issueReady=0. Write-back x3 on the same cycle as a third issue of rd=3 -> issueReady=1 and busy[3] stays 1.
- rdBusy: x9 busy, rdAddr[1]=9, no write-back -> rdBusy[1]=1. Write-back x9 that cycle -> rdBusy[1]=0 with BYPASS=1, rdBusy[1]=1 with BYPASS=0, and busy[9]=0 the next cycle.
- Flush: busy on x2, x4 and x31; assert flush with issueValid and rd=6 -> issueReady=0, busyVec = 0 next cycle, busy[6] not set.
